// File: rtl/mul_acc_collect_if.sv
// Bundle between the multiplier-side producer and the frame-sum collector:
// product/done flag in, frame result out over a valid/ready handshake.
interface mul_acc_collect_if #(
    parameter int DW = 16,
    parameter int AW = 24
);
    logic [DW-1:0] prod_i;
    logic          fl_i;
    logic          clr_i;
    logic [AW-1:0] sum_o;
    logic          sum_vld_o;
    logic          sum_rdy_i;
    logic          ovf_o;
    logic          lost_o;
    logic [7:0]    cnt_o;

    modport slave (
        input  prod_i, fl_i, clr_i, sum_rdy_i,
        output sum_o, sum_vld_o, ovf_o, lost_o, cnt_o
    );

    modport master (
        output prod_i, fl_i, clr_i, sum_rdy_i,
        input  sum_o, sum_vld_o, ovf_o, lost_o, cnt_o
    );
endinterface

// File: rtl/mul_acc_collect.sv
// Collects N multiplier products (one per rising edge of the done flag) into a
// saturating frame sum and hands it downstream over a valid/ready handshake.
module mul_acc_collect #(
    parameter int DW = 16,
    parameter int AW = 24,
    parameter int N  = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mul_acc_collect_if.slave bus
);
    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    logic [0:0]    r_state;
    logic          r_fl_d;
    logic [AW-1:0] r_acc;
    logic [7:0]    r_cnt;
    logic          r_ovf_f;
    logic [AW-1:0] r_sum;
    logic          r_vld;
    logic          r_ovf;
    logic          r_lost;

    logic          w_ev;
    logic [AW:0]   w_sum_wide;
    logic          w_sat;
    logic [AW-1:0] w_acc_new;
    logic          w_last;

    assign w_ev       = bus.fl_i & ~r_fl_d;
    assign w_sum_wide = {1'b0, r_acc} + {{(AW + 1 - DW){1'b0}}, bus.prod_i};
    assign w_sat      = w_sum_wide[AW];
    assign w_acc_new  = w_sat ? {AW{1'b1}} : w_sum_wide[AW-1:0];
    assign w_last     = (r_cnt == 8'(N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_ACC;
            r_fl_d  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf_f <= 1'b0;
            r_sum   <= '0;
            r_vld   <= 1'b0;
            r_ovf   <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            r_fl_d <= bus.fl_i;
            // Abort wins over both a new product and a pending handshake.
            if (bus.clr_i) begin
                r_state <= ST_ACC;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ovf_f <= 1'b0;
                r_vld   <= 1'b0;
                r_ovf   <= 1'b0;
                r_lost  <= 1'b0;
            end else if (r_state == ST_ACC) begin
                if (w_ev) begin
                    if (w_last) begin
                        r_sum   <= w_acc_new;
                        r_ovf   <= r_ovf_f | w_sat;
                        r_vld   <= 1'b1;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf_f <= 1'b0;
                        r_state <= ST_OUT;
                    end else begin
                        r_acc   <= w_acc_new;
                        r_cnt   <= r_cnt + 8'd1;
                        r_ovf_f <= r_ovf_f | w_sat;
                    end
                end
            end else begin
                // Products arriving while the result waits are dropped, including on the handshake cycle.
                if (w_ev) begin
                    r_lost <= 1'b1;
                end
                if (bus.sum_rdy_i && r_vld) begin
                    r_vld   <= 1'b0;
                    r_state <= ST_ACC;
                end
            end
        end
    end

    assign bus.sum_o     = r_sum;
    assign bus.sum_vld_o = r_vld;
    assign bus.ovf_o     = r_ovf;
    assign bus.lost_o    = r_lost;
    assign bus.cnt_o     = r_cnt;
endmodule

// File: tb/tb_mul_acc_collect.sv
// Randomized + directed bench for mul_acc_collect: an integer-arithmetic frame
// model feeds a result scoreboard that a separate monitor drains.
module tb_mul_acc_collect;
    localparam int DW = 16;
    localparam int AW = 18;
    localparam int N  = 8;
    localparam longint MAXV = (longint'(1) << AW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_acc_collect_if #(.DW(DW), .AW(AW)) bus ();

    mul_acc_collect #(.DW(DW), .AW(AW), .N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_res    = 0;
    bit done     = 1'b0;

    typedef struct {
        longint sum;
        bit     ovf;
    } res_t;
    res_t exp_q[$];

    // Reference model: frame-level integer state, advanced once per clock edge.
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovff = 1'b0;
    bit     m_wait = 1'b0;
    bit     m_lost = 1'b0;
    bit     m_fl_prev = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_ovff = 0; m_wait = 0; m_lost = 0; m_fl_prev = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input longint p, input bit f, input bit c, input bit r);
        bit ev;
        longint s;
        ev = f && !m_fl_prev;
        m_fl_prev = f;
        if (c) begin
            m_acc = 0; m_cnt = 0; m_ovff = 0; m_wait = 0; m_lost = 0;
        end else if (!m_wait) begin
            if (ev) begin
                s = m_acc + p;
                if (s > MAXV) begin
                    s = MAXV;
                    m_ovff = 1;
                end
                m_cnt++;
                if (m_cnt == N) begin
                    exp_q.push_back('{sum: s, ovf: m_ovff});
                    m_acc = 0; m_cnt = 0; m_ovff = 0; m_wait = 1;
                end else begin
                    m_acc = s;
                end
            end
        end else begin
            if (ev) m_lost = 1;
            if (r) m_wait = 0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge; the model takes the next rising edge.
    task automatic cyc(input logic [DW-1:0] p, input bit f, input bit c, input bit r);
        @(negedge clk);
        bus.prod_i    = p;
        bus.fl_i      = f;
        bus.clr_i     = c;
        bus.sum_rdy_i = r;
        if (!rst) model_step(longint'(p), f, c, r);
    endtask

    task automatic pulse(input logic [DW-1:0] p, input bit r);
        cyc(p, 1'b1, 1'b0, r);
        cyc(p, 1'b0, 1'b0, r);
    endtask

    // Monitor: per-cycle status checks plus scoreboard pops on each new result.
    initial begin
        bit   prev_vld;
        res_t cur;
        prev_vld = 1'b0;
        cur = '{sum: 0, ovf: 0};
        while (!done) begin
            @(posedge clk);
            #1;
            if (done) break;
            chk("cnt_o", longint'(bus.cnt_o), longint'(m_cnt));
            chk("sum_vld_o", longint'(bus.sum_vld_o), longint'(m_wait));
            chk("lost_o", longint'(bus.lost_o), longint'(m_lost));
            if (bus.sum_vld_o && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_result: got sum %0h, expected no result", bus.sum_o);
                end else begin
                    cur = exp_q.pop_front();
                    n_res++;
                    $display("result %0d: sum=%0h ovf=%0b", n_res, bus.sum_o, bus.ovf_o);
                    chk("sum_o", longint'(bus.sum_o), cur.sum);
                    chk("ovf_o", longint'(bus.ovf_o), longint'(cur.ovf));
                end
            end else if (bus.sum_vld_o) begin
                chk("sum_o_held", longint'(bus.sum_o), cur.sum);
                chk("ovf_o_held", longint'(bus.ovf_o), longint'(cur.ovf));
            end
            prev_vld = bus.sum_vld_o;
        end
    end

    initial begin
        logic [DW-1:0] p;
        bit f, pf;
        bus.prod_i = '0; bus.fl_i = 1'b0; bus.clr_i = 1'b0; bus.sum_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Eight products of 3 -> 24, no overflow.
        for (int i = 0; i < N; i++) pulse(16'h0003, 1'b1);
        repeat (3) cyc(16'h0, 1'b0, 1'b0, 1'b1);

        // Level held 20 cycles counts once; finish the frame with zeros.
        repeat (20) cyc(16'h0005, 1'b1, 1'b0, 1'b1);
        cyc(16'h0005, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N - 1; i++) pulse(16'h0000, 1'b1);
        repeat (2) cyc(16'h0, 1'b0, 1'b0, 1'b1);

        // Saturating frame, then a clean small frame.
        for (int i = 0; i < N; i++) pulse(16'hFFFF, 1'b1);
        for (int i = 0; i < N; i++) pulse(16'h0001, 1'b1);
        repeat (2) cyc(16'h0, 1'b0, 1'b0, 1'b1);

        // Result held with ready low, product dropped, then accepted.
        for (int i = 0; i < N; i++) pulse(16'h0100, 1'b0);
        repeat (4) cyc(16'h0, 1'b0, 1'b0, 1'b0);
        pulse(16'h1234, 1'b0);
        repeat (4) cyc(16'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(16'h0, 1'b0, 1'b0, 1'b1);

        // Frame abort mid-frame with the flag still high, then a clean frame.
        for (int i = 0; i < 5; i++) pulse(16'h0011, 1'b1);
        cyc(16'h0011, 1'b1, 1'b1, 1'b1);
        cyc(16'h0011, 1'b1, 1'b0, 1'b1);
        cyc(16'h0011, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) pulse(16'h0022, 1'b1);
        repeat (2) cyc(16'h0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame takes effect before the next clock edge.
        for (int i = 0; i < 5; i++) pulse(16'h0033, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_cnt_o", longint'(bus.cnt_o), 0);
        chk("rst_sum_o", longint'(bus.sum_o), 0);
        chk("rst_vld_o", longint'(bus.sum_vld_o), 0);
        chk("rst_lost_o", longint'(bus.lost_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back frames with ready tied high.
        for (int i = 0; i < 2 * N; i++) pulse(16'h0001, 1'b1);
        repeat (2) cyc(16'h0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        p = '0;
        pf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            f = 1'($urandom_range(0, 1));
            if (f && !pf)
                p = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(60000, 65535))
                                                : DW'($urandom_range(0, 65535));
            cyc(p, f, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0));
            pf = f;
        end

        repeat (4) cyc(16'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        done = 1'b1;
        chk("pending_results", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
